// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix pixel feeder: default panel geometry,
// framebuffer word layout and read-address packing.
package led_matrix_pkg;

    localparam int unsigned DEF_PANEL_COLS = 64;
    localparam int unsigned DEF_PANEL_ROWS = 32;
    localparam int unsigned DEF_COLOR_BITS = 8;

    localparam int unsigned SCAN_ROWS = DEF_PANEL_ROWS / 2;
    localparam int unsigned COL_W     = $clog2(DEF_PANEL_COLS);
    localparam int unsigned ROW_W     = $clog2(SCAN_ROWS);
    localparam int unsigned PIX_W     = 3 * DEF_COLOR_BITS;

    // Field index of each colour channel inside a framebuffer word {R1,G1,B1,R0,G0,B0}
    localparam int unsigned CH_B0 = 0;
    localparam int unsigned CH_G0 = 1;
    localparam int unsigned CH_R0 = 2;
    localparam int unsigned CH_B1 = 3;
    localparam int unsigned CH_G1 = 4;
    localparam int unsigned CH_R1 = 5;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Read address ordered {bank, scan_row, column}
    function automatic logic [31:0] fb_addr(input logic bank, input logic [31:0] row,
                                            input logic [31:0] col,
                                            input int unsigned row_w, input int unsigned col_w);
        return (32'(bank) << (row_w + col_w)) | (row << col_w) | col;
    endfunction

endpackage

// File: rtl/led_bcm_sequencer.sv
// Row / bit-plane / repeat counters implementing binary-code-modulation line sequencing.
module led_bcm_sequencer
    import led_matrix_pkg::*;
#(
    parameter int unsigned SCAN_N     = 16,
    parameter int unsigned COLOR_BITS = 8,
    parameter int unsigned ROWW       = 4,
    parameter int unsigned PLW        = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    output logic [ROWW-1:0] row,
    output logic [PLW-1:0]  plane,
    output logic            frame_wrap
);

    logic [ROWW-1:0]       row_q, row_d;
    logic [PLW-1:0]        plane_q, plane_d;
    logic [COLOR_BITS-1:0] rep_q, rep_d;
    logic [COLOR_BITS-1:0] rep_lim;
    logic                  rep_done, last_plane, last_row;

    // Plane b is held for 2^b lines
    assign rep_lim    = COLOR_BITS'((32'd1 << plane_q) - 32'd1);
    assign rep_done   = (rep_q == rep_lim);
    assign last_plane = (plane_q == PLW'(COLOR_BITS - 1));
    assign last_row   = (row_q == ROWW'(SCAN_N - 1));
    assign frame_wrap = advance && rep_done && last_plane && last_row;

    always_comb begin
        row_d   = row_q;
        plane_d = plane_q;
        rep_d   = rep_q;
        if (advance) begin
            if (!rep_done) begin
                rep_d = rep_q + COLOR_BITS'(1);
            end else begin
                rep_d = '0;
                if (!last_plane) begin
                    plane_d = plane_q + PLW'(1);
                end else begin
                    plane_d = '0;
                    row_d   = last_row ? '0 : row_q + ROWW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            plane_q <= '0;
            rep_q   <= '0;
        end else begin
            row_q   <= row_d;
            plane_q <= plane_d;
            rep_q   <= rep_d;
        end
    end

    assign row   = row_q;
    assign plane = plane_q;

endmodule

// File: rtl/led_matrix_pixel_feeder.sv
// Feeds HUB75 colour/address lines from a double-buffered framebuffer using BCM bit planes,
// and swaps the displayed bank at frame boundaries on request.
module led_matrix_pixel_feeder
    import led_matrix_pkg::*;
#(
    parameter int unsigned PANEL_COLS = 64,
    parameter int unsigned PANEL_ROWS = 32,
    parameter int unsigned COLOR_BITS = 8,
    localparam int unsigned SCAN_N = PANEL_ROWS / 2,
    localparam int unsigned COLW   = clog2_min1(PANEL_COLS),
    localparam int unsigned ROWW   = clog2_min1(SCAN_N),
    localparam int unsigned PLW    = clog2_min1(COLOR_BITS),
    localparam int unsigned ADDR_W = 1 + ROWW + COLW,
    localparam int unsigned DATA_W = 6 * COLOR_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [COLW-1:0]   frame_column,
    input  logic              line_sync,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              active_bank,
    output logic              frame_sync,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [DATA_W-1:0] fb_rd_data,
    output logic [5:0]        matrix_rgb,
    output logic [ROWW-1:0]   matrix_addr
);

    logic              advance, frame_wrap;
    logic [ROWW-1:0]   row;
    logic [PLW-1:0]    plane;

    logic              bank_q, bank_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    logic              fsync_q, fsync_d;
    logic [5:0]        rgb_q, rgb_d;
    logic [ROWW-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0] shifted;

    assign advance = enable && line_sync;

    led_bcm_sequencer #(
        .SCAN_N     (SCAN_N),
        .COLOR_BITS (COLOR_BITS),
        .ROWW       (ROWW),
        .PLW        (PLW)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (advance),
        .row        (row),
        .plane      (plane),
        .frame_wrap (frame_wrap)
    );

    assign fb_rd_en   = enable;
    assign fb_rd_addr = ADDR_W'(fb_addr(bank_q, 32'(row), 32'(frame_column), ROWW, COLW));

    always_comb begin
        bank_d  = bank_q;
        pend_d  = pend_q;
        rgb_d   = rgb_q;
        maddr_d = maddr_q;
        ack_d   = 1'b0;
        fsync_d = 1'b0;
        shifted = '0;
        if (enable) begin
            // Pick bit `plane` of every channel field
            rgb_d = '0;
            for (int unsigned k = CH_B0; k <= CH_R1; k++) begin
                shifted = fb_rd_data >> (k * COLOR_BITS + 32'(plane));
                rgb_d   = rgb_d | (6'(shifted[0]) << k);
            end
            if (line_sync) begin
                maddr_d = row;
            end
            if (frame_wrap) begin
                fsync_d = 1'b1;
                pend_d  = 1'b0;
                if (pend_q || swap_req) begin
                    bank_d = ~bank_q;
                    ack_d  = 1'b1;
                end
            end else if (swap_req) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            fsync_q <= 1'b0;
            rgb_q   <= '0;
            maddr_q <= '0;
        end else begin
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            fsync_q <= fsync_d;
            rgb_q   <= rgb_d;
            maddr_q <= maddr_d;
        end
    end

    assign swap_ack    = ack_q;
    assign active_bank = bank_q;
    assign frame_sync  = fsync_q;
    assign matrix_rgb  = rgb_q;
    assign matrix_addr = maddr_q;

endmodule

// File: tb/tb_led_matrix_pixel_feeder.sv
// Bench for led_matrix_pixel_feeder: directed scenarios plus random traffic checked
// every cycle against a line-count based model of BCM sequencing and bank swapping.
module tb_led_matrix_pixel_feeder;

    localparam int COLS  = 4;
    localparam int ROWS  = 4;
    localparam int CB    = 2;
    localparam int SCAN  = ROWS / 2;
    localparam int LPR   = (1 << CB) - 1;
    localparam int FRAME = LPR * SCAN;

    logic        clk, rst_n, enable, line_sync, swap_req;
    logic [1:0]  frame_column;
    logic        swap_ack, active_bank, frame_sync, fb_rd_en;
    logic [3:0]  fb_rd_addr;
    logic [11:0] fb_rd_data;
    logic [5:0]  matrix_rgb;
    logic [0:0]  matrix_addr;

    logic [11:0] mem [16];
    logic [11:0] ram_q = '0;

    int n_checks = 0;
    int n_fail   = 0;

    led_matrix_pixel_feeder #(
        .PANEL_COLS (COLS),
        .PANEL_ROWS (ROWS),
        .COLOR_BITS (CB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_column (frame_column),
        .line_sync    (line_sync),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .active_bank  (active_bank),
        .frame_sync   (frame_sync),
        .fb_rd_en     (fb_rd_en),
        .fb_rd_addr   (fb_rd_addr),
        .fb_rd_data   (fb_rd_data),
        .matrix_rgb   (matrix_rgb),
        .matrix_addr  (matrix_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer RAM, one clock of read latency
    always @(posedge clk) if (fb_rd_en) ram_q <= mem[fb_rd_addr];
    assign fb_rd_data = ram_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int row_of(input int l);
        return l / LPR;
    endfunction

    // Line offset o within a row shows plane floor(log2(o+1))
    function automatic int plane_of(input int l);
        int o = l % LPR;
        int p = 0;
        while ((1 << (p + 1)) <= o + 1) p++;
        return p;
    endfunction

    function automatic logic [3:0] exp_addr(input logic b, input int r, input logic [1:0] c);
        return {b, 1'(r), c};
    endfunction

    // Behavioural model: a line index within the frame plus bank / pending state
    int          m_line = 0;
    logic        m_bank = 0, m_pend = 0, m_fs = 0, m_ack = 0;
    logic [5:0]  m_rgb = '0;
    logic [0:0]  m_maddr = '0;
    logic [11:0] m_ram_q = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_line = 0; m_bank = 0; m_pend = 0; m_fs = 0; m_ack = 0;
            m_rgb = '0; m_maddr = '0;
        end else begin
            m_fs  = 0;
            m_ack = 0;
            if (enable) begin
                logic [11:0] t;
                int p;
                p = plane_of(m_line);
                m_rgb = '0;
                for (int k = 0; k < 6; k++) begin
                    t = m_ram_q >> (k * CB + p);
                    m_rgb = m_rgb | (6'(t[0]) << k);
                end
                m_ram_q = mem[exp_addr(m_bank, row_of(m_line), frame_column)];
                if (line_sync) begin
                    m_maddr = 1'(row_of(m_line));
                    if (m_line == FRAME - 1) begin
                        m_fs = 1;
                        if (m_pend || swap_req) begin
                            m_bank = ~m_bank;
                            m_ack  = 1;
                        end
                        m_pend = 0;
                    end else if (swap_req) begin
                        m_pend = 1;
                    end
                    m_line = (m_line + 1) % FRAME;
                end else if (swap_req) begin
                    m_pend = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #1;
        chk("rgb",      32'(matrix_rgb),  32'(m_rgb));
        chk("maddr",    32'(matrix_addr), 32'(m_maddr));
        chk("fsync",    32'(frame_sync),  32'(m_fs));
        chk("ack",      32'(swap_ack),    32'(m_ack));
        chk("bank",     32'(active_bank), 32'(m_bank));
        chk("rd_en",    32'(fb_rd_en),    32'(enable));
        chk("rd_addr",  32'(fb_rd_addr),
            32'(exp_addr(m_bank, rst_n ? row_of(m_line) : 0, frame_column)));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ls();
        line_sync = 1'b1;
        @(negedge clk);
        line_sync = 1'b0;
    endtask

    task automatic do_reset();
        enable = 0; line_sync = 0; swap_req = 0; frame_column = 0;
        rst_n = 0;
        cyc(2);
        rst_n = 1;
        cyc(1);
    endtask

    initial begin
        logic [3:0] a;
        logic [0:0] exp_seq [6];
        exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
        exp_seq[3] = 1'b1; exp_seq[4] = 1'b1; exp_seq[5] = 1'b1;
        rst_n = 0; enable = 0; line_sync = 0; swap_req = 0; frame_column = 0;
        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
        mem[4'b0010] = 12'h060;  // bank 0, row 0, col 2: R0=2'b10, B1=2'b01
        do_reset();
        chk("rst_maddr", 32'(matrix_addr), 32'h0);
        chk("rst_bank",  32'(active_bank), 32'h0);
        chk("rst_rgb",   32'(matrix_rgb),  32'h0);

        // Bit-plane extraction and plane/repeat progression on one pixel
        enable = 1; frame_column = 2;
        cyc(2);
        chk("rgb_plane0", 32'(matrix_rgb), 32'h08);
        pulse_ls();
        cyc(1);
        chk("rgb_plane1_rep0", 32'(matrix_rgb), 32'h04);
        pulse_ls();
        cyc(1);
        chk("rgb_plane1_rep1", 32'(matrix_rgb), 32'h04);

        // Row address sequence over one frame
        do_reset();
        enable = 1;
        for (int i = 0; i < 6; i++) begin
            pulse_ls();
            chk("seq_maddr", 32'(matrix_addr), 32'(exp_seq[i]));
            chk("seq_fsync", 32'(frame_sync), (i == 5) ? 32'h1 : 32'h0);
        end

        // Mid-frame swap request takes effect at frame end
        do_reset();
        enable = 1;
        pulse_ls();
        swap_req = 1; cyc(1); swap_req = 0;
        for (int i = 0; i < 4; i++) begin
            pulse_ls();
            chk("swap_hold_bank", 32'(active_bank), 32'h0);
        end
        pulse_ls();
        chk("swap_bank", 32'(active_bank), 32'h1);
        chk("swap_ack",  32'(swap_ack),    32'h1);
        cyc(1);
        chk("swap_ack_once", 32'(swap_ack), 32'h0);
        a = fb_rd_addr;
        chk("swap_addr_msb", 32'(a[3]), 32'h1);

        // Swap request coincident with the wrapping line_sync
        for (int i = 0; i < 5; i++) pulse_ls();
        line_sync = 1; swap_req = 1;
        cyc(1);
        line_sync = 0; swap_req = 0;
        chk("coinc_bank", 32'(active_bank), 32'h0);
        chk("coinc_ack",  32'(swap_ack),    32'h1);

        // Two requests before a frame end give one toggle
        swap_req = 1; cyc(1); swap_req = 0;
        pulse_ls();
        swap_req = 1; cyc(1); swap_req = 0;
        for (int i = 0; i < 5; i++) pulse_ls();
        chk("dbl_bank", 32'(active_bank), 32'h1);
        for (int i = 0; i < 6; i++) pulse_ls();
        chk("dbl_bank_stays", 32'(active_bank), 32'h1);

        // Disabled cycles ignore line_sync and swap_req
        for (int i = 0; i < 4; i++) pulse_ls();
        enable = 0; line_sync = 1; swap_req = 1;
        cyc(1);
        line_sync = 0; swap_req = 0;
        chk("dis_rd_en", 32'(fb_rd_en),    32'h0);
        chk("dis_maddr", 32'(matrix_addr), 32'h1);
        enable = 1;
        pulse_ls();
        chk("dis_fsync_early", 32'(frame_sync), 32'h0);
        pulse_ls();
        chk("dis_fsync_wrap", 32'(frame_sync), 32'h1);
        chk("dis_no_swap",    32'(active_bank), 32'h1);

        // Reset in the middle of a row
        pulse_ls();
        rst_n = 0; enable = 0; frame_column = 0;
        #1;
        chk("mid_rst_outs",
            32'({matrix_rgb, matrix_addr, frame_sync, swap_ack, active_bank, fb_rd_addr}), 32'h0);
        @(negedge clk);
        rst_n = 1; enable = 1;
        for (int i = 0; i < 3; i++) pulse_ls();
        chk("rst_resume_row0", 32'(matrix_addr), 32'h0);
        pulse_ls();
        chk("rst_resume_row1", 32'(matrix_addr), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0; enable = 0;
            end else begin
                rst_n = 1;
                enable = ($urandom_range(0, 9) != 0);
            end
            line_sync = ($urandom_range(0, 4) == 0);
            swap_req  = ($urandom_range(0, 19) == 0);
            frame_column = 2'(i / 2);
            if (i % 50 == 0) mem[4'($urandom_range(0, 15))] = 12'($urandom);
            @(negedge clk);
        end
        rst_n = 1; line_sync = 0; swap_req = 0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
